// File: rtl/mo_pkg.sv
// mo_pkg -- shared definitions for the motion-object line scanner:
// FSM state encoding, MO RAM word-layout field offsets and object height.
package mo_pkg;

  // Object height in lines (power of two).
  localparam int unsigned OBJ_H = 16;

  // Word 2i   = {pic, attr}
  // Word 2i+1 = {ypos, xpos}
  localparam int unsigned PIC_LSB        = 8;
  localparam int unsigned ATTR_LSB       = 0;
  localparam int unsigned YPOS_LSB       = 8;
  localparam int unsigned XPOS_LSB       = 0;
  localparam int unsigned ATTR_VFLIP_BIT = 7;

  typedef enum logic [2:0] {
    IDLE,
    RD_POS,
    CHK_POS,
    RD_ATTR,
    CAP_ATTR,
    EMIT,
    FIN
  } mo_state_t;

endpackage

// File: rtl/mo_scan_if.sv
// mo_scan_if -- MO RAM video read port plus emitted-object handshake.
// master: the scanner; slave: RAM + renderer side.
interface mo_scan_if;
  logic [7:0]  ram_a;
  logic        ram_r;
  logic [15:0] ram_do;
  logic        obj_valid;
  logic        obj_ready;
  logic [27:0] obj_data;

  modport master (output ram_a, ram_r, obj_valid, obj_data,
                  input  ram_do, obj_ready);
  modport slave  (input  ram_a, ram_r, obj_valid, obj_data,
                  output ram_do, obj_ready);
endinterface

// File: rtl/mo_row_calc.sv
// mo_row_calc -- combinational hit test: row = (vline - ypos) mod 256,
// hit when row < HEIGHT. Optional vertical flip under MO_SCAN_VFLIP_EN.
module mo_row_calc
  import mo_pkg::*;
#(
  parameter int unsigned HEIGHT = OBJ_H
) (
  input  logic [7:0] vline,
  input  logic [7:0] ypos,
  input  logic       vflip,
  output logic       hit,
  output logic [3:0] row
);

  localparam logic [7:0] H8   = 8'(HEIGHT);
  localparam logic [3:0] RMAX = 4'(HEIGHT - 1);

  logic [7:0] diff;

  // Wrapping subtract, range compare and optional flip of the row index.
  always_comb begin
    diff = vline - ypos;
    hit  = diff < H8;
`ifdef MO_SCAN_VFLIP_EN
    row  = vflip ? (RMAX - diff[3:0]) : diff[3:0];
`else
    row  = diff[3:0];
`endif
  end

`ifndef MO_SCAN_VFLIP_EN
  logic unused_vflip;
  assign unused_vflip = vflip;
`endif

endmodule

// File: rtl/mo_scan.sv
// mo_scan -- per-line motion-object scanner. Walks NUM_OBJ objects in MO RAM,
// emits up to MAX_PER_LINE visible objects per line over a valid/ready link.
// Optional feature macro: MO_SCAN_VFLIP_EN (attr[7] flips the emitted row).
module mo_scan #(
  parameter int unsigned NUM_OBJ      = 64,
  parameter int unsigned MAX_PER_LINE = 8,
  parameter int unsigned OBJ_H        = mo_pkg::OBJ_H
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [7:0]  vline,
  mo_scan_if.master   bus,
  output logic        scan_done,
  output logic        overrun
);

  import mo_pkg::*;

  localparam logic [7:0] LAST = 8'(NUM_OBJ);
  localparam logic [4:0] MAXL = 5'(MAX_PER_LINE);

  mo_state_t   state_q, state_d;
  logic [6:0]  idx_q, idx_d;
  logic [4:0]  hits_q, hits_d;
  logic [7:0]  vline_q, vline_d;
  logic [7:0]  ram_a_q;
  logic [7:0]  xpos_q, ypos_q;
  logic [27:0] obj_data_q;
  logic [7:0]  idx_p1;
  logic [7:0]  rd_addr;
  logic [7:0]  calc_ypos;
  logic        calc_hit;
  logic [3:0]  calc_row;
  logic        advance;
  logic        restart;

  // One row calculator serves both the hit test (CHK_POS, fresh ypos from
  // RAM) and the final row with flip (CAP_ATTR, stored ypos + fresh attr).
  assign calc_ypos = (state_q == CHK_POS) ? bus.ram_do[YPOS_LSB +: 8] : ypos_q;

  mo_row_calc #(.HEIGHT(OBJ_H)) u_row_calc (
    .vline (vline_q),
    .ypos  (calc_ypos),
    .vflip (bus.ram_do[ATTR_LSB + ATTR_VFLIP_BIT]),
    .hit   (calc_hit),
    .row   (calc_row)
  );

  assign idx_p1  = {1'b0, idx_q} + 8'd1;
  assign restart = line_start && (state_q != IDLE);

  // Next-state, index/hit-count update and restart on a mid-scan line_start.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hits_d  = hits_q;
    vline_d = vline_q;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_start) begin
          vline_d = vline;
          idx_d   = '0;
          hits_d  = '0;
          state_d = RD_POS;
        end
      end
      RD_POS:   state_d = CHK_POS;
      CHK_POS: begin
        if (calc_hit) state_d = RD_ATTR;
        else          advance = 1'b1;
      end
      RD_ATTR:  state_d = CAP_ATTR;
      CAP_ATTR: state_d = EMIT;
      EMIT: begin
        if (bus.obj_ready) begin
          hits_d  = hits_q + 5'd1;
          advance = 1'b1;
        end
      end
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (advance) begin
      if (idx_p1 == LAST || hits_d == MAXL) begin
        state_d = FIN;
      end else begin
        idx_d   = idx_q + 7'd1;
        state_d = RD_POS;
      end
    end

    // The EMIT transfer (if any) has already been taken above; the restart
    // then overrides whatever the scan would have done next.
    if (restart) begin
      vline_d = vline;
      idx_d   = '0;
      hits_d  = '0;
      state_d = RD_POS;
    end
  end

  // Output decode: RAM strobe only in the read states, address otherwise held.
  always_comb begin
    rd_addr       = (state_q == RD_ATTR) ? {idx_q, 1'b0} : {idx_q, 1'b1};
    bus.ram_r     = (state_q == RD_POS) || (state_q == RD_ATTR);
    bus.ram_a     = bus.ram_r ? rd_addr : ram_a_q;
    bus.obj_valid = (state_q == EMIT);
    bus.obj_data  = obj_data_q;
    scan_done     = (state_q == FIN);
  end

  // State, counters, captured object fields and sticky overrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      hits_q     <= '0;
      vline_q    <= '0;
      ram_a_q    <= '0;
      xpos_q     <= '0;
      ypos_q     <= '0;
      obj_data_q <= '0;
      overrun    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hits_q  <= hits_d;
      vline_q <= vline_d;
      if (bus.ram_r) ram_a_q <= rd_addr;
      if (state_q == CHK_POS) begin
        xpos_q <= bus.ram_do[XPOS_LSB +: 8];
        ypos_q <= bus.ram_do[YPOS_LSB +: 8];
      end
      if (state_q == CAP_ATTR) begin
        obj_data_q <= {bus.ram_do[PIC_LSB +: 8], bus.ram_do[ATTR_LSB +: 8],
                       xpos_q, calc_row};
      end
      if (restart) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mo_scan.sv
// tb_mo_scan -- directed self-checking bench for mo_scan with a behavioural
// synchronous MO RAM. Expected values are hand-computed constants.
module tb_mo_scan;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       line_start = 1'b0;
  logic [7:0] vline = '0;
  logic       scan_done;
  logic       overrun;

  mo_scan_if bus ();

  mo_scan #(.NUM_OBJ(64), .MAX_PER_LINE(8), .OBJ_H(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .line_start (line_start),
    .vline      (vline),
    .bus        (bus),
    .scan_done  (scan_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:255];

  // Synchronous RAM: data appears the cycle after the strobe.
  always @(posedge clk) if (bus.ram_r) bus.ram_do <= mem[bus.ram_a];

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_obj(input int i, input logic [7:0] pic, input logic [7:0] attr,
                         input logic [7:0] y, input logic [7:0] x);
    mem[2*i]   = {pic, attr};
    mem[2*i+1] = {y, x};
  endtask

  task automatic fill_bg();
    for (int i = 0; i < 128; i++) set_obj(i, 8'h00, 8'h00, 8'hC0, 8'h00);
  endtask

  int          n_rd;
  logic        done_seen;
  logic [27:0] emit_q [$];

  // Observe from the current negedge until scan_done or the cycle budget.
  task automatic monitor(input int budget);
    n_rd = 0;
    done_seen = 1'b0;
    emit_q.delete();
    for (int c = 0; c < budget; c++) begin
      if (bus.ram_r) n_rd++;
      if (bus.obj_valid && bus.obj_ready) emit_q.push_back(bus.obj_data);
      if (scan_done) begin
        done_seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_start(input logic [7:0] vl);
    @(negedge clk);
    vline = vl;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic run_scan(input logic [7:0] vl);
    pulse_start(vl);
    monitor(2000);
  endtask

  function automatic logic [27:0] emit_at(input int k);
    return (emit_q.size() > k) ? emit_q[k] : 28'hFFFFFFF;
  endfunction

  task automatic wait_valid(output logic found);
    found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (bus.obj_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  logic [27:0] held;
  logic        found;
  int          bad;
  logic [3:0]  flip_row;

  initial begin
    bus.obj_ready = 1'b1;
    fill_bg();
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_ram_a", bus.ram_a, 0);
    check_eq("rst_ram_r", bus.ram_r, 0);
    check_eq("rst_obj_valid", bus.obj_valid, 0);
    check_eq("rst_obj_data", bus.obj_data, 0);
    check_eq("rst_scan_done", scan_done, 0);
    check_eq("rst_overrun", overrun, 0);
    reset_n = 1'b1;

    // Single hit: obj 3 at y=0x40, line 0x45 -> row 5
    set_obj(3, 8'h5A, 8'h01, 8'h40, 8'h20);
    run_scan(8'h45);
    check_eq("single_done", done_seen, 1);
    check_eq("single_emits", emit_q.size(), 1);
    check_eq("single_data", emit_at(0), 28'h5A01205);
    check_eq("single_reads", n_rd, 65);

    // Wrap across line 255/0
    fill_bg();
    set_obj(5, 8'h22, 8'h00, 8'hF8, 8'h11);
    run_scan(8'h03);
    check_eq("wrap_emits", emit_q.size(), 1);
    check_eq("wrap_data", emit_at(0), 28'h220011B);
    run_scan(8'h08);
    check_eq("wrap_miss_done", done_seen, 1);
    check_eq("wrap_miss_emits", emit_q.size(), 0);
    check_eq("wrap_miss_reads", n_rd, 64);

    // Per-line limit: every object visible, only 8 emitted
    for (int i = 0; i < 64; i++) set_obj(i, 8'(i), 8'h00, 8'h10, 8'(i));
    run_scan(8'h10);
    check_eq("limit_done", done_seen, 1);
    check_eq("limit_emits", emit_q.size(), 8);
    check_eq("limit_first", emit_at(0), 28'h0000000);
    check_eq("limit_last", emit_at(7), 28'h0700070);
    check_eq("limit_reads", n_rd, 16);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.ram_r) bad++;
    end
    check_eq("limit_idle_reads", bad, 0);
    check_eq("limit_ram_a_hold", bus.ram_a, 8'h0E);

    // Backpressure: renderer stalls for 10 cycles
    fill_bg();
    set_obj(3, 8'h5A, 8'h01, 8'h40, 8'h20);
    bus.obj_ready = 1'b0;
    pulse_start(8'h45);
    wait_valid(found);
    check_eq("bp_valid_seen", found, 1);
    held = bus.obj_data;
    check_eq("bp_data", held, 28'h5A01205);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.obj_valid || bus.obj_data !== held || bus.ram_r) bad++;
    end
    check_eq("bp_stall_stable", bad, 0);
    bus.obj_ready = 1'b1;
    monitor(2000);
    check_eq("bp_emits", emit_q.size(), 1);
    check_eq("bp_done", done_seen, 1);

    // Overrun: restart mid-scan from index 0
    fill_bg();
    check_eq("ovr_before", overrun, 0);
    pulse_start(8'h45);
    repeat (20) @(negedge clk);
    vline = 8'h45;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (bus.ram_r) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("ovr_restart_read", found, 1);
    check_eq("ovr_restart_addr", bus.ram_a, 8'h01);
    check_eq("ovr_flag", overrun, 1);
    monitor(2000);
    check_eq("ovr_rescan_reads", n_rd, 64);
    check_eq("ovr_rescan_done", done_seen, 1);

    // line_start coincident with an EMIT transfer: restart rescans the object
    set_obj(3, 8'h5A, 8'h01, 8'h40, 8'h20);
    bus.obj_ready = 1'b0;
    pulse_start(8'h45);
    wait_valid(found);
    check_eq("pri_valid_seen", found, 1);
    bus.obj_ready = 1'b1;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    check_eq("pri_valid_dropped", bus.obj_valid, 0);
    monitor(2000);
    check_eq("pri_rescan_emits", emit_q.size(), 1);
    check_eq("pri_rescan_data", emit_at(0), 28'h5A01205);

    // Vertical flip bit
    fill_bg();
    set_obj(0, 8'h44, 8'h80, 8'h40, 8'h33);
`ifdef MO_SCAN_VFLIP_EN
    flip_row = 4'hD;
`else
    flip_row = 4'h2;
`endif
    run_scan(8'h42);
    check_eq("flip_emits", emit_q.size(), 1);
    check_eq("flip_data", emit_at(0), {8'h44, 8'h80, 8'h33, flip_row});
    check_eq("ovr_sticky", overrun, 1);

    // Reset mid-scan: abandoned, no scan_done, overrun cleared
    pulse_start(8'h42);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_ram_r", bus.ram_r, 0);
    check_eq("mid_rst_overrun", overrun, 0);
    check_eq("mid_rst_ram_a", bus.ram_a, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (scan_done || bus.ram_r || bus.obj_valid) bad++;
    end
    check_eq("mid_rst_quiet", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
